// File: rtl/rx_handle_check_if.sv
// Handshake bundle between the PIE decoder / command FSM and rx_handle_check.
// The master side drives the bit stream and handle; the slave side returns the check results.
interface rx_handle_check_if #(
  parameter int CNT_W = 8
);
  logic             new_cmd;
  logic             bit_vld;
  logic             bit_in;
  logic             frm_end;
  logic [15:0]      handle;
  logic [15:0]      rx_hdl;
  logic [CNT_W-1:0] bit_num;
  logic             crc_ok;
  logic             hdl_ok;
  logic             chk_done;

  modport master (
    output new_cmd, bit_vld, bit_in, frm_end, handle,
    input  rx_hdl, bit_num, crc_ok, hdl_ok, chk_done
  );

  modport slave (
    input  new_cmd, bit_vld, bit_in, frm_end, handle,
    output rx_hdl, bit_num, crc_ok, hdl_ok, chk_done
  );
endinterface

// File: rtl/rx_handle_check.sv
// Receive-side Gen2 handle checker: CRC-16/CCITT over the frame, captures the 16 bits
// ahead of the CRC and compares them with the tag's current handle.
module rx_handle_check #(
  parameter int MAX_BITS = 128,
  parameter int CNT_W    = 8
) (
  input  logic               DOUB_BLF,
  input  logic               rst_n,
  rx_handle_check_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(32);
  localparam logic [15:0]      RESIDUE = 16'h1D0F;

  state_t           state_r;
  logic [15:0]      crc_r;
  logic [31:0]      sr_r;
  logic [CNT_W-1:0] bit_num_r;
  logic             ovf_r;
  logic [15:0]      rx_hdl_r;
  logic             crc_ok_r;
  logic             hdl_ok_r;
  logic             chk_done_r;

  logic [15:0]      crc_nxt_s;
  logic             len_ok_s;
  logic             crc_pass_s;

  // CRC-16/CCITT serial step (poly 0x1021, MSB first).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Next CRC value and evaluation terms.
  always_comb begin
    crc_nxt_s  = crc16_step(crc_r, bus.bit_in);
    len_ok_s   = (bit_num_r >= MIN_CNT) && !ovf_r;
    crc_pass_s = len_ok_s && (crc_r == RESIDUE);
  end

  // Control FSM with frame datapath and registered results.
  always_ff @(posedge DOUB_BLF or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      crc_r      <= 16'hFFFF;
      sr_r       <= 32'h0000_0000;
      bit_num_r  <= '0;
      ovf_r      <= 1'b0;
      rx_hdl_r   <= 16'h0000;
      crc_ok_r   <= 1'b0;
      hdl_ok_r   <= 1'b0;
      chk_done_r <= 1'b0;
    end else if (bus.new_cmd) begin
      state_r    <= RECV;
      crc_r      <= 16'hFFFF;
      sr_r       <= 32'h0000_0000;
      bit_num_r  <= '0;
      ovf_r      <= 1'b0;
      rx_hdl_r   <= 16'h0000;
      crc_ok_r   <= 1'b0;
      hdl_ok_r   <= 1'b0;
      chk_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        RECV: begin
          if (bus.bit_vld) begin
            crc_r <= crc_nxt_s;
            sr_r  <= {sr_r[30:0], bus.bit_in};
            if (bit_num_r == MAX_CNT) begin
              ovf_r <= 1'b1;
            end else begin
              bit_num_r <= bit_num_r + CNT_W'(1);
            end
          end
          if (bus.frm_end) begin
            state_r <= EVAL;
          end
        end
        EVAL: begin
          rx_hdl_r   <= sr_r[31:16];
          crc_ok_r   <= crc_pass_s;
          hdl_ok_r   <= crc_pass_s && (sr_r[31:16] == bus.handle);
          chk_done_r <= 1'b1;
          state_r    <= DONE;
        end
        DONE:    state_r <= DONE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.rx_hdl   = rx_hdl_r;
  assign bus.bit_num  = bit_num_r;
  assign bus.crc_ok   = crc_ok_r;
  assign bus.hdl_ok   = hdl_ok_r;
  assign bus.chk_done = chk_done_r;

endmodule

// File: tb/tb_rx_handle_check.sv
// Directed self-checking bench for rx_handle_check.
module tb_rx_handle_check;

  logic doub_blf = 1'b0;
  logic rst_n    = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  rx_handle_check_if #(.CNT_W(8)) bus ();

  rx_handle_check #(.MAX_BITS(128), .CNT_W(8)) dut (
    .DOUB_BLF (doub_blf),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 doub_blf = ~doub_blf;

  logic [71:0]  ascii_v;
  logic [87:0]  golden_v;
  logic [255:0] frame_v;
  logic [15:0]  c_v;

  task automatic tick();
    @(posedge doub_blf);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd();
    bus.new_cmd = 1'b1;
    tick();
    bus.new_cmd = 1'b0;
  endtask

  // Sends v[n-1:0] MSB first; optionally raises frm_end with the last bit.
  task automatic send_vec(input logic [255:0] v, input int n, input logic end_on_last);
    for (int i = n - 1; i >= 0; i--) begin
      bus.bit_vld = 1'b1;
      bus.bit_in  = v[i];
      bus.frm_end = end_on_last && (i == 0);
      tick();
    end
    bus.bit_vld = 1'b0;
    bus.bit_in  = 1'b0;
    bus.frm_end = 1'b0;
  endtask

  // Ends the frame (unless already ended) and steps to the result cycle.
  task automatic end_frame(input string tag, input logic raise_end);
    if (raise_end) begin
      bus.frm_end = 1'b1;
      tick();
      bus.frm_end = 1'b0;
    end
    chk({tag, "_done_early"}, 32'(bus.chk_done), 32'd0);
    tick();
  endtask

  task automatic check_res(input string tag, input logic crc_e, input logic hdl_e,
                           input logic [15:0] rx_e, input logic [7:0] num_e);
    chk({tag, "_chk_done"}, 32'(bus.chk_done), 32'd1);
    chk({tag, "_crc_ok"},   32'(bus.crc_ok),   32'(crc_e));
    chk({tag, "_hdl_ok"},   32'(bus.hdl_ok),   32'(hdl_e));
    chk({tag, "_rx_hdl"},   32'(bus.rx_hdl),   32'(rx_e));
    chk({tag, "_bit_num"},  32'(bus.bit_num),  32'(num_e));
  endtask

  function automatic logic [15:0] ref_crc(input logic [255:0] v, input int n);
    logic [15:0] c;
    logic        f;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      f = v[i] ^ c[15];
      c = c << 1;
      if (f) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  initial begin
    bus.new_cmd = 1'b0;
    bus.bit_vld = 1'b0;
    bus.bit_in  = 1'b0;
    bus.frm_end = 1'b0;
    bus.handle  = 16'h3839;
    ascii_v     = "123456789";
    golden_v    = {ascii_v, 16'hD64E};

    #12;
    chk("rst_chk_done", 32'(bus.chk_done), 32'd0);
    chk("rst_rx_hdl",   32'(bus.rx_hdl),   32'd0);
    chk("rst_bit_num",  32'(bus.bit_num),  32'd0);
    rst_n = 1'b1;
    tick();

    // Golden frame, handle match
    start_cmd();
    send_vec(256'(golden_v), 88, 1'b0);
    chk("gold_crc_reg", 32'(dut.crc_r), 32'h1D0F);
    end_frame("gold", 1'b1);
    check_res("gold", 1'b1, 1'b1, 16'h3839, 8'd88);

    // Handle mismatch
    bus.handle = 16'h3838;
    start_cmd();
    chk("rearm_drop", 32'(bus.chk_done), 32'd0);
    send_vec(256'(golden_v), 88, 1'b0);
    end_frame("mism", 1'b1);
    check_res("mism", 1'b1, 1'b0, 16'h3839, 8'd88);

    // Re-arm from DONE, second frame passes
    bus.handle = 16'h3839;
    start_cmd();
    chk("rearm2_drop", 32'(bus.chk_done), 32'd0);
    send_vec(256'(golden_v), 88, 1'b0);
    end_frame("rearm", 1'b1);
    check_res("rearm", 1'b1, 1'b1, 16'h3839, 8'd88);

    // CRC error: 6th transmitted bit inverted
    frame_v = 256'(golden_v);
    frame_v[82] = ~frame_v[82];
    start_cmd();
    send_vec(frame_v, 88, 1'b0);
    end_frame("crcerr", 1'b1);
    check_res("crcerr", 1'b0, 1'b0, 16'h3839, 8'd88);

    // 20-bit short frame: "12" plus high nibble of "3"
    start_cmd();
    send_vec(256'(golden_v[87:68]), 20, 1'b0);
    end_frame("short", 1'b1);
    check_res("short", 1'b0, 1'b0, 16'h0003, 8'd20);

    // frm_end together with the final CRC bit
    start_cmd();
    send_vec(256'(golden_v), 88, 1'b1);
    end_frame("merge", 1'b0);
    check_res("merge", 1'b1, 1'b1, 16'h3839, 8'd88);

    // Exactly MAX_BITS with valid CRC passes
    bus.handle = 16'hA5C3;
    frame_v = 256'({96'h0123_4567_89AB_CDEF_F0E1_D2C3, 16'hA5C3});
    c_v = ref_crc(frame_v, 112);
    frame_v = {frame_v[239:0], ~c_v};
    start_cmd();
    send_vec(frame_v, 128, 1'b0);
    end_frame("max", 1'b1);
    check_res("max", 1'b1, 1'b1, 16'hA5C3, 8'd128);

    // MAX_BITS+1 with valid CRC residue still fails on length
    frame_v = 256'({1'b1, 96'h0123_4567_89AB_CDEF_F0E1_D2C3, 16'hA5C3});
    c_v = ref_crc(frame_v, 113);
    frame_v = {frame_v[239:0], ~c_v};
    start_cmd();
    send_vec(frame_v, 129, 1'b0);
    chk("ovf_crc_reg", 32'(dut.crc_r), 32'h1D0F);
    end_frame("ovf", 1'b1);
    check_res("ovf", 1'b0, 1'b0, 16'hA5C3, 8'd128);

    // new_cmd with bit_vld and frm_end in the same cycle
    bus.new_cmd = 1'b1;
    bus.bit_vld = 1'b1;
    bus.bit_in  = 1'b1;
    bus.frm_end = 1'b1;
    tick();
    bus.new_cmd = 1'b0;
    bus.bit_vld = 1'b0;
    bus.frm_end = 1'b0;
    chk("same_bit_num",  32'(bus.bit_num),  32'd0);
    chk("same_state",    32'(dut.state_r),  32'd1);
    chk("same_chk_done", 32'(bus.chk_done), 32'd0);

    // Reset mid-frame after 40 bits
    send_vec(256'(golden_v), 40, 1'b0);
    chk("pre_rst_bit_num", 32'(bus.bit_num), 32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bit_num",  32'(bus.bit_num),  32'd0);
    chk("mid_rst_rx_hdl",   32'(bus.rx_hdl),   32'd0);
    chk("mid_rst_crc_ok",   32'(bus.crc_ok),   32'd0);
    chk("mid_rst_hdl_ok",   32'(bus.hdl_ok),   32'd0);
    chk("mid_rst_chk_done", 32'(bus.chk_done), 32'd0);
    chk("mid_rst_state",    32'(dut.state_r),  32'd0);
    chk("mid_rst_crc_reg",  32'(dut.crc_r),    32'hFFFF);
    tick();
    rst_n = 1'b1;
    bus.frm_end = 1'b1;
    tick();
    bus.frm_end = 1'b0;
    tick();
    chk("post_rst_idle_done", 32'(bus.chk_done), 32'd0);
    chk("post_rst_state",     32'(dut.state_r),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
